// File: rtl/pattern_scan_pkg.sv
// Shared types, constants and helpers for the pattern scan arbiter slice.
package pattern_scan_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    REPORT = 2'd2
  } state_e;

  localparam int IDX_W = 3;

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic [15:0] max);
    return (v >= max) ? max : v + 16'd1;
  endfunction

endpackage

// File: rtl/pattern_scan_arbiter_if.sv
// Requester-side bundle of the pattern scan arbiter: serial streams, config, result.
interface pattern_scan_arbiter_if
  import pattern_scan_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int PAT_W = 8,
  parameter int CNT_W = 8
);
  logic [NREQ-1:0]  req;
  logic [NREQ-1:0]  bit_in;
  logic [NREQ-1:0]  bit_vld;
  logic [NREQ-1:0]  last;
  logic [PAT_W-1:0] pattern;
  logic [3:0]       pat_len;
  logic             overlap_en;
  logic [NREQ-1:0]  grant;
  logic             busy;
  logic             done;
  logic [IDX_W-1:0] done_id;
  logic [CNT_W-1:0] match_cnt;
  logic             abort;

  modport master (
    output req, bit_in, bit_vld, last, pattern, pat_len, overlap_en,
    input  grant, busy, done, done_id, match_cnt, abort
  );

  modport slave (
    input  req, bit_in, bit_vld, last, pattern, pat_len, overlap_en,
    output grant, busy, done, done_id, match_cnt, abort
  );
endinterface

// File: rtl/pattern_scan_arbiter_matcher.sv
// Serial matcher: shift history plus bits-seen count; match is a combinational
// pulse for the bit being shifted in on this edge.
module serial_pattern_matcher
  import pattern_scan_pkg::*;
#(
  parameter int PAT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             shift_en,
  input  logic             bit_in,
  input  logic [PAT_W-1:0] pattern,
  input  logic [3:0]       len,
  input  logic             overlap_en,
  output logic             match
);
  logic [PAT_W-1:0] hist_q, hist_d;
  logic [3:0]       seen_q, seen_d;
  logic [PAT_W-1:0] len_mask;
  logic [PAT_W-1:0] hist_shift;
  logic [3:0]       seen_inc;

  genvar gi;
  generate
    for (gi = 0; gi < PAT_W; gi++) begin : g_mask
      assign len_mask[gi] = (4'(gi) < len);
    end
  endgenerate

  assign hist_shift = {hist_q[PAT_W-2:0], bit_in};
  assign seen_inc   = 4'(sat_inc(16'(seen_q), 16'(PAT_W)));
  // A zero length never matches, even though the empty mask would compare equal.
  assign match = shift_en && (len != 4'd0) && (seen_inc >= len) &&
                 (((hist_shift ^ pattern) & len_mask) == '0);

  always_comb begin
    hist_d = hist_q;
    seen_d = seen_q;
    if (clr) begin
      hist_d = '0;
      seen_d = '0;
    end else if (shift_en) begin
      hist_d = hist_shift;
      seen_d = (match && !overlap_en) ? 4'd0 : seen_inc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= '0;
      seen_q <= '0;
    end else begin
      hist_q <= hist_d;
      seen_q <= seen_d;
    end
  end
endmodule

// File: rtl/pattern_scan_arbiter.sv
// Round-robin owner of one serial pattern matcher; reports one count per frame.
module pattern_scan_arbiter
  import pattern_scan_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int PAT_W = 8,
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic rst,
  pattern_scan_arbiter_if.slave bus
);
  localparam logic [1:0]       S_IDLE   = IDLE;
  localparam logic [1:0]       S_SCAN   = SCAN;
  localparam logic [1:0]       S_REPORT = REPORT;
  localparam logic [3:0]       PAT_W4   = 4'(PAT_W);
  localparam logic [15:0]      CNT_MAX  = 16'((1 << CNT_W) - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREQ - 1);

  logic [1:0]       state_q, state_d;
  logic [NREQ-1:0]  grant_q, grant_d;
  logic [IDX_W-1:0] gidx_q, gidx_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [IDX_W-1:0] done_id_q, done_id_d;
  logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
  logic             abort_q, abort_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [3:0]       len_q, len_d;
  logic             ovl_q, ovl_d;

  logic [NREQ-1:0]  hi_mask, req_hi;
  logic             pick_vld;
  logic [IDX_W-1:0] pick_idx;
  logic             g_req, g_vld, g_last, g_bit;
  logic             shift_en, clr, match;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_hi
      assign hi_mask[gi] = (IDX_W'(gi) >= ptr_q);
    end
  endgenerate

  // Requests at or above the pointer win; otherwise wrap to the lowest request.
  assign req_hi = bus.req & hi_mask;
  always_comb begin
    pick_vld = |bus.req;
    pick_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if ((req_hi != '0) ? req_hi[i] : bus.req[i]) pick_idx = IDX_W'(i);
    end
  end

  assign g_req  = |(bus.req & grant_q);
  assign g_vld  = |(bus.bit_vld & grant_q);
  assign g_last = |(bus.last & grant_q);
  assign g_bit  = |(bus.bit_in & grant_q);

  serial_pattern_matcher #(.PAT_W(PAT_W)) u_matcher (
    .clk(clk), .rst(rst), .clr(clr), .shift_en(shift_en), .bit_in(g_bit),
    .pattern(pat_q), .len(len_q), .overlap_en(ovl_q), .match(match)
  );

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    gidx_d      = gidx_q;
    ptr_d       = ptr_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    done_id_d   = done_id_q;
    match_cnt_d = match_cnt_q;
    abort_d     = abort_q;
    cnt_d       = cnt_q;
    pat_d       = pat_q;
    len_d       = len_q;
    ovl_d       = ovl_q;
    shift_en    = 1'b0;
    clr         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          grant_d = NREQ'(1) << pick_idx;
          gidx_d  = pick_idx;
          busy_d  = 1'b1;
          pat_d   = bus.pattern;
          len_d   = (bus.pat_len > PAT_W4) ? PAT_W4 : bus.pat_len;
          ovl_d   = bus.overlap_en;
          cnt_d   = '0;
          clr     = 1'b1;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        // A bit carrying last is still counted even if req fell on that edge.
        shift_en = g_vld && (g_req || g_last);
        if (match) cnt_d = CNT_W'(sat_inc(16'(cnt_q), CNT_MAX));
        if ((g_vld && g_last) || !g_req) begin
          state_d     = S_REPORT;
          grant_d     = '0;
          busy_d      = 1'b0;
          ptr_d       = (gidx_q == LAST_IDX) ? '0 : gidx_q + IDX_W'(1);
          done_d      = 1'b1;
          done_id_d   = gidx_q;
          match_cnt_d = cnt_d;
          abort_d     = !(g_vld && g_last);
        end
      end
      S_REPORT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      grant_q     <= '0;
      gidx_q      <= '0;
      ptr_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      done_id_q   <= '0;
      match_cnt_q <= '0;
      abort_q     <= 1'b0;
      cnt_q       <= '0;
      pat_q       <= '0;
      len_q       <= '0;
      ovl_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      gidx_q      <= gidx_d;
      ptr_q       <= ptr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      done_id_q   <= done_id_d;
      match_cnt_q <= match_cnt_d;
      abort_q     <= abort_d;
      cnt_q       <= cnt_d;
      pat_q       <= pat_d;
      len_q       <= len_d;
      ovl_q       <= ovl_d;
    end
  end

  assign bus.grant     = grant_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.done_id   = done_id_q;
  assign bus.match_cnt = match_cnt_q;
  assign bus.abort     = abort_q;
endmodule

// File: tb/tb_pattern_scan_arbiter.sv
// Directed bench for pattern_scan_arbiter: counting, overlap, round-robin,
// saturation, length edges, abort and asynchronous reset.
module tb_pattern_scan_arbiter;
  localparam int NREQ  = 4;
  localparam int PAT_W = 8;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  pattern_scan_arbiter_if #(.NREQ(NREQ), .PAT_W(PAT_W), .CNT_W(CNT_W)) bus ();
  pattern_scan_arbiter_if #(.NREQ(NREQ), .PAT_W(PAT_W), .CNT_W(2))     bus_sat ();

  pattern_scan_arbiter #(.NREQ(NREQ), .PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  pattern_scan_arbiter #(.NREQ(NREQ), .PAT_W(PAT_W), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .bus(bus_sat)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.req = '0; bus.bit_in = '0; bus.bit_vld = '0; bus.last = '0;
    bus.pattern = '0; bus.pat_len = '0; bus.overlap_en = 1'b0;
    bus_sat.req = '0; bus_sat.bit_in = '0; bus_sat.bit_vld = '0; bus_sat.last = '0;
    bus_sat.pattern = '0; bus_sat.pat_len = '0; bus_sat.overlap_en = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic set_config(input logic [PAT_W-1:0] pat, input logic [3:0] len, input logic ovl);
    bus.pattern = pat; bus.pat_len = len; bus.overlap_en = ovl;
  endtask

  // s[k] is the k-th bit in time order on requester idx.
  task automatic send_bits(input int idx, input logic [15:0] s, input int n, input bit with_last);
    for (int k = 0; k < n; k++) begin
      bus.bit_vld = NREQ'(1) << idx;
      bus.bit_in  = s[k] ? (NREQ'(1) << idx) : '0;
      bus.last    = (with_last && k == n - 1) ? (NREQ'(1) << idx) : '0;
      tick();
    end
    bus.bit_vld = '0; bus.bit_in = '0; bus.last = '0;
  endtask

  task automatic test_reset();
    apply_reset();
    total++;
    if (bus.grant !== 4'b0000) begin bad++; $display("FAIL reset_grant: got %b want 0000", bus.grant); end
    total++;
    if ({bus.busy, bus.done, bus.abort} !== 3'b000) begin
      bad++; $display("FAIL reset_flags: busy/done/abort got %b want 000", {bus.busy, bus.done, bus.abort});
    end
    total++;
    if (bus.match_cnt !== 8'd0 || bus.done_id !== 3'd0) begin
      bad++; $display("FAIL reset_result: cnt=%0d id=%0d want 0/0", bus.match_cnt, bus.done_id);
    end
    $display("test_reset: grant=%b busy=%b done=%b", bus.grant, bus.busy, bus.done);
  endtask

  task automatic test_basic();
    set_config(8'b01, 4'd2, 1'b0);
    bus.req = 4'b0001;
    tick();
    total++;
    if (bus.grant !== 4'b0001 || bus.busy !== 1'b1) begin
      bad++; $display("FAIL basic_grant: grant=%b busy=%b want 0001/1", bus.grant, bus.busy);
    end
    // Config changes after the grant edge must be ignored.
    set_config(8'hFF, 4'd1, 1'b1);
    send_bits(0, 16'b10110, 5, 1'b1);
    total++;
    if (bus.done !== 1'b1 || bus.done_id !== 3'd0 || bus.match_cnt !== 8'd2 || bus.abort !== 1'b0) begin
      bad++; $display("FAIL basic_result: done=%b id=%0d cnt=%0d abort=%b want 1/0/2/0",
                      bus.done, bus.done_id, bus.match_cnt, bus.abort);
    end
    total++;
    if (bus.grant !== 4'b0000 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL basic_release: grant=%b busy=%b want 0000/0", bus.grant, bus.busy);
    end
    bus.req = '0;
    tick();
    total++;
    if (bus.done !== 1'b0 || bus.match_cnt !== 8'd2) begin
      bad++; $display("FAIL basic_hold: done=%b cnt=%0d want 0/2", bus.done, bus.match_cnt);
    end
    $display("test_basic: id=%0d cnt=%0d", bus.done_id, bus.match_cnt);
    tick();
  endtask

  task automatic test_overlap();
    for (int o = 1; o >= 0; o--) begin
      set_config(8'b101, 4'd3, o[0]);
      bus.req = 4'b0001;
      tick();
      send_bits(0, 16'b10101, 5, 1'b1);
      total++;
      if (bus.done !== 1'b1 || bus.match_cnt !== ((o == 1) ? 8'd2 : 8'd1)) begin
        bad++; $display("FAIL overlap_%0d: done=%b cnt=%0d want 1/%0d", o, bus.done, bus.match_cnt, (o == 1) ? 2 : 1);
      end
      $display("test_overlap: overlap_en=%0d cnt=%0d", o, bus.match_cnt);
      bus.req = '0;
      tick();
      tick();
    end
  endtask

  task automatic test_round_robin();
    apply_reset();
    bus.req = 4'b1111;
    tick();
    for (int f = 0; f < 5; f++) begin
      logic [NREQ-1:0] exp_g;
      exp_g = NREQ'(1) << (f % NREQ);
      total++;
      if (bus.grant !== exp_g) begin bad++; $display("FAIL rr_grant_%0d: got %b want %b", f, bus.grant, exp_g); end
      send_bits(f % NREQ, 16'b11, 2, 1'b1);
      total++;
      if (bus.done !== 1'b1 || bus.done_id !== 3'(f % NREQ) || bus.grant !== 4'b0000) begin
        bad++; $display("FAIL rr_report_%0d: done=%b id=%0d grant=%b want 1/%0d/0000",
                        f, bus.done, bus.done_id, bus.grant, f % NREQ);
      end
      if (f == 4) bus.req = '0;
      tick();
      total++;
      if (bus.grant !== 4'b0000 || bus.done !== 1'b0) begin
        bad++; $display("FAIL rr_gap_%0d: grant=%b done=%b want 0000/0", f, bus.grant, bus.done);
      end
      $display("test_round_robin: frame=%0d id=%0d", f, bus.done_id);
      tick();
    end
  endtask

  task automatic test_saturation();
    bus_sat.pattern = 8'b1; bus_sat.pat_len = 4'd1; bus_sat.overlap_en = 1'b0;
    bus_sat.req = 4'b0001;
    tick();
    total++;
    if (bus_sat.grant !== 4'b0001) begin bad++; $display("FAIL sat_grant: got %b want 0001", bus_sat.grant); end
    for (int k = 0; k < 5; k++) begin
      bus_sat.bit_vld = 4'b0001; bus_sat.bit_in = 4'b0001;
      bus_sat.last = (k == 4) ? 4'b0001 : 4'b0000;
      tick();
    end
    bus_sat.bit_vld = '0; bus_sat.bit_in = '0; bus_sat.last = '0; bus_sat.req = '0;
    total++;
    if (bus_sat.done !== 1'b1 || bus_sat.match_cnt !== 2'd3) begin
      bad++; $display("FAIL sat_cnt: done=%b cnt=%0d want 1/3", bus_sat.done, bus_sat.match_cnt);
    end
    $display("test_saturation: cnt=%0d", bus_sat.match_cnt);
    tick();
    tick();
  endtask

  task automatic test_length();
    set_config(8'h00, 4'd0, 1'b1);
    bus.req = 4'b0010;
    tick();
    send_bits(1, 16'b0000, 4, 1'b1);
    total++;
    if (bus.done !== 1'b1 || bus.done_id !== 3'd1 || bus.match_cnt !== 8'd0) begin
      bad++; $display("FAIL len_zero: done=%b id=%0d cnt=%0d want 1/1/0", bus.done, bus.done_id, bus.match_cnt);
    end
    $display("test_length: len=0 cnt=%0d", bus.match_cnt);
    bus.req = '0;
    tick();
    tick();
    set_config(8'hFF, 4'd15, 1'b0);
    bus.req = 4'b0010;
    tick();
    send_bits(1, 16'hFF, 8, 1'b1);
    total++;
    if (bus.done !== 1'b1 || bus.match_cnt !== 8'd1) begin
      bad++; $display("FAIL len_clamp: done=%b cnt=%0d want 1/1", bus.done, bus.match_cnt);
    end
    $display("test_length: len=15 cnt=%0d", bus.match_cnt);
    bus.req = '0;
    tick();
    tick();
  endtask

  task automatic test_abort();
    set_config(8'b01, 4'd2, 1'b0);
    bus.req = 4'b0100;
    tick();
    total++;
    if (bus.grant !== 4'b0100) begin bad++; $display("FAIL abort_grant: got %b want 0100", bus.grant); end
    send_bits(2, 16'b010, 3, 1'b0);
    bus.req = '0;
    tick();
    total++;
    if (bus.done !== 1'b1 || bus.done_id !== 3'd2 || bus.abort !== 1'b1 || bus.match_cnt !== 8'd1) begin
      bad++; $display("FAIL abort_result: done=%b id=%0d abort=%b cnt=%0d want 1/2/1/1",
                      bus.done, bus.done_id, bus.abort, bus.match_cnt);
    end
    tick();
    total++;
    if (bus.done !== 1'b0 || bus.abort !== 1'b1) begin
      bad++; $display("FAIL abort_hold: done=%b abort=%b want 0/1", bus.done, bus.abort);
    end
    $display("test_abort: id=%0d abort=%b cnt=%0d", bus.done_id, bus.abort, bus.match_cnt);
    tick();
  endtask

  task automatic test_reset_mid_scan();
    bit seen_done;
    set_config(8'b1, 4'd1, 1'b0);
    bus.req = 4'b0010;
    tick();
    send_bits(1, 16'b11, 2, 1'b0);
    rst = 1'b1;
    #1;
    total++;
    if (bus.grant !== 4'b0000 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.match_cnt !== 8'd0) begin
      bad++; $display("FAIL rst_async: grant=%b busy=%b done=%b cnt=%0d want 0000/0/0/0",
                      bus.grant, bus.busy, bus.done, bus.match_cnt);
    end
    bus.req = '0;
    #2;
    rst = 1'b0;
    seen_done = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (bus.done === 1'b1) seen_done = 1'b1;
    end
    total++;
    if (seen_done !== 1'b0) begin bad++; $display("FAIL rst_no_done: got done pulse=%b want 0", seen_done); end
    $display("test_reset_mid_scan: grant=%b done_seen=%b", bus.grant, seen_done);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overlap();
    test_round_robin();
    test_saturation();
    test_length();
    test_abort();
    test_reset_mid_scan();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pattern_scan_arbiter.md
Name: pattern_scan_arbiter

Overview:
- Shares one serial bit-pattern matcher among NREQ requesters. Each requester streams one frame of serial bits.
- Round-robin arbitration grants the matcher to one requester at a time.
- At grant, the controller captures that requester's pattern configuration, then counts pattern occurrences in the frame.
- At frame end, it reports a one-cycle result. Sits between serial-input front ends and the status/interrupt logic.

Parameters:
NREQ, 4, number of requesters (2..8)
PAT_W, 8, maximum pattern length in bits
CNT_W, 8, match counter width

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
req  input  NREQ  per-requester request, held high for the whole frame
bit_in  input  NREQ  per-requester serial data bit
bit_vld  input  NREQ  per-requester bit-valid strobe
last  input  NREQ  per-requester end-of-frame marker, qualified by bit_vld
pattern  input  PAT_W  pattern bits; bit 0 = most recent bit
pat_len  input  4  pattern length in bits, 1..PAT_W
overlap_en  input  1  1 = overlapping matches count
grant  output  NREQ  one-hot grant, registered
busy  output  1  high while in SCAN
done  output  1  one-cycle result strobe
done_id  output  3  index of the requester just reported
match_cnt  output  CNT_W  match count of the reported frame, held until next done
abort  output  1  reported frame was cut short by req drop; valid with done, held

Behaviour:
- Reset: state IDLE; grant=0, busy=0, done=0, done_id=0, match_cnt=0, abort=0; round-robin pointer=0; shift history and counters cleared.
- States: IDLE, SCAN, REPORT.
- IDLE:
  - If any req is high, pick the first requester at or after the pointer, wrapping modulo NREQ.
  - On that edge: set grant one-hot and busy=1; capture pattern, pat_len and overlap_en into registers; clear shift register, bits-seen count and match count.
  - Go to SCAN. Latency req -> grant = 1 cycle.
  - With no req, stay in IDLE.
- SCAN:
  - Use only the granted requester's signals; other inputs are ignored.
  - On each edge where the granted bit_vld=1:
    - Shift bit_in into bit 0 of the history.
    - Increment bits-seen, saturating at PAT_W.
    - A match occurs when bits-seen (including this bit) >= captured length and the low captured-length history bits equal the pattern's low bits.
    - On a match, increment the match count, saturating at 2^CNT_W-1.
    - On a match with overlap disabled, reset bits-seen to 0 so the next match needs a full new pattern length.
  - If the granted last=1 with bit_vld on the same edge: process that bit first, then go to REPORT. On that edge clear grant and busy, and set the pointer to grant index+1 (wrap).
  - If the granted req drops while in SCAN (no valid last): go to REPORT with abort=1. The count reflects bits accepted so far, and the pointer advances the same way.
- REPORT: done=1 for exactly one cycle; done_id, match_cnt and abort are updated on entry and then held. Next state is IDLE, so a new grant comes at the earliest 2 cycles after the last-bit edge.
- Length rules:
  - pat_len=0 is captured as "no match possible": the frame completes with count 0.
  - pat_len>PAT_W is clamped to PAT_W.
- Configuration changes during SCAN have no effect.
- Reset mid-SCAN: immediate return to reset values. No done is produced for the interrupted frame.
- req must not be raised for a frame while that requester's previous done is pending. If it is, arbitration simply treats it as a new request in IDLE.

Decomposition:
- Shared package pattern_scan_pkg holds:
  - state enum (IDLE, SCAN, REPORT);
  - the index width constant (3 bits);
  - the saturating-increment helper function.
- One natural sub-module, serial_pattern_matcher. It holds the shift history, bits-seen, overlap handling and match pulse, with ports clk, rst, clr, shift_en, bit_in, pattern, len, overlap_en -> match.
- The arbiter/FSM stays in the top module.

Test Plan:
- Basic count: req[0] only, pattern=8'b01 (0 then 1), pat_len=2, overlap_en=0; stream 0,1,1,0,1 with last on the 5th bit -> grant=0001 one cycle after req; done pulse one cycle after the last edge with done_id=0, match_cnt=2, abort=0.
- Overlap: pattern 101, pat_len=3, stream 1,0,1,0,1 -> with overlap_en=1, match_cnt=2; with overlap_en=0, match_cnt=1.
- Round-robin: req=1111 continuously, each frame 2 bits -> grant sequence 0001, 0010, 0100, 1000, 0001, with no grant during REPORT cycles.
- Saturation: CNT_W=2, pattern=1, pat_len=1, stream of 5 ones -> match_cnt=3.
- Length edges: pat_len=0 on a 4-bit frame -> match_cnt=0. pat_len=15 with PAT_W=8 behaves as length 8: 8 ones against pattern FF gives 1 match.
- Abort and reset:
  - req[2] drops after 3 bits of stream 0,1,0 with pattern 01 -> done_id=2, abort=1, match_cnt=1.
  - rst asserted mid-SCAN -> grant, busy, done and match_cnt are 0 asynchronously, and no done pulse follows.
